// File: rtl/data_compare4_pkg.sv
// rtl/data_compare4_pkg.sv - shared cascade codes and one-hot helper for data_compare4
package data_compare4_pkg;

  localparam logic [2:0] CMP_GT   = 3'b100;
  localparam logic [2:0] CMP_EQ   = 3'b010;
  localparam logic [2:0] CMP_LT   = 3'b001;
  localparam logic [2:0] CMP_NONE = 3'b000;

  // True when the cascade code is exactly one of GT, EQ or LT.
  function automatic logic is_onehot3(input logic [2:0] code);
    return (code == CMP_GT) || (code == CMP_EQ) || (code == CMP_LT);
  endfunction

endpackage

// File: rtl/compare_slice4.sv
// rtl/compare_slice4.sv - combinational 4-bit magnitude slice with cascade pass-through on ties
module compare_slice4
  import data_compare4_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic [2:0] cas_in,
  output logic [2:0] cas_out
);

  // This slice decides on inequality; a tie defers to the less-significant result untouched.
  always_comb begin
    cas_out = cas_in;
    if (a > b) begin
      cas_out = CMP_GT;
    end else if (a < b) begin
      cas_out = CMP_LT;
    end
  end

endmodule

// File: rtl/data_compare4.sv
// rtl/data_compare4.sv - cascadable registered magnitude comparator; DATA_COMPARE4_CHECK_EN adds oErr
module data_compare4
  import data_compare4_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [WIDTH-1:0] iData_a,
  input  logic [WIDTH-1:0] iData_b,
  input  logic [2:0]       iData,
  output logic [2:0]       oData
`ifdef DATA_COMPARE4_CHECK_EN
  ,
  output logic             oErr
`endif
);

  localparam int NUM_SLICES = WIDTH / 4;

  if (((WIDTH % 4) != 0) || (WIDTH < 4)) begin : gWidthCheck
    $error("data_compare4: WIDTH must be a positive multiple of 4");
  end

  // casChain[k] is the cascade code entering slice k; the last entry is the full-width result.
  logic [NUM_SLICES:0][2:0] casChain;

  assign casChain[0] = iData;

  for (genvar k = 0; k < NUM_SLICES; k++) begin : gSlice
    compare_slice4 uSlice (
      .a       (iData_a[4*k +: 4]),
      .b       (iData_b[4*k +: 4]),
      .cas_in  (casChain[k]),
      .cas_out (casChain[k+1])
    );
  end

  // Register the most-significant slice result; reset clears to the "no result" code.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oData <= CMP_NONE;
    end else begin
      oData <= casChain[NUM_SLICES];
    end
  end

`ifdef DATA_COMPARE4_CHECK_EN
  // Flag a malformed cascade code only when it actually reaches the output, i.e. on a full tie.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oErr <= 1'b0;
    end else begin
      oErr <= (iData_a == iData_b) && !is_onehot3(iData);
    end
  end
`endif

endmodule

// File: tb/tb_data_compare4.sv
// tb/tb_data_compare4.sv - self-checking bench for data_compare4 at WIDTH 4 and 8
module tb_data_compare4;

  logic       clk;
  logic       rst;
  logic [3:0] a4, b4;
  logic [2:0] c4;
  logic [2:0] out4;
  logic [7:0] a8, b8;
  logic [2:0] c8;
  logic [2:0] out8;
`ifdef DATA_COMPARE4_CHECK_EN
  logic       err4, err8;
`endif

  int vectors = 0;
  int miscompares = 0;

  data_compare4 #(.WIDTH(4)) dut4 (
    .iClk    (clk),
    .iRst    (rst),
    .iData_a (a4),
    .iData_b (b4),
    .iData   (c4),
    .oData   (out4)
`ifdef DATA_COMPARE4_CHECK_EN
    ,
    .oErr    (err4)
`endif
  );

  data_compare4 #(.WIDTH(8)) dut8 (
    .iClk    (clk),
    .iRst    (rst),
    .iData_a (a8),
    .iData_b (b8),
    .iData   (c8),
    .oData   (out8)
`ifdef DATA_COMPARE4_CHECK_EN
    ,
    .oErr    (err8)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: full-width unsigned compare; a tie returns the cascade code as given.
  function automatic logic [2:0] refCmp(input int unsigned a, input int unsigned b, input logic [2:0] cas);
    if (a > b) return 3'b100;
    if (a < b) return 3'b001;
    return cas;
  endfunction

  function automatic logic refErr(input int unsigned a, input int unsigned b, input logic [2:0] cas);
    return (a == b) && ($countones(cas) != 1);
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply one vector to both DUTs, clock once, then check one cycle later away from the edge.
  task automatic step(input logic r,
                      input logic [3:0] ia4, input logic [3:0] ib4, input logic [2:0] ic4,
                      input logic [2:0] e4, input logic er4,
                      input logic [7:0] ia8, input logic [7:0] ib8, input logic [2:0] ic8,
                      input logic [2:0] e8, input logic er8,
                      input string tag);
    rst = r;
    a4 = ia4; b4 = ib4; c4 = ic4;
    a8 = ia8; b8 = ib8; c8 = ic8;
    @(posedge clk);
    #1;
    chk({tag, "_w4"}, out4, e4);
    chk({tag, "_w8"}, out8, e8);
`ifdef DATA_COMPARE4_CHECK_EN
    chk({tag, "_err_w4"}, {2'b00, err4}, {2'b00, er4});
    chk({tag, "_err_w8"}, {2'b00, err8}, {2'b00, er8});
`else
    if (er4 || er8) begin end
`endif
  endtask

  initial begin
    logic       r;
    logic [3:0] ra4, rb4;
    logic [7:0] ra8, rb8;
    logic [2:0] rc4, rc8;

    rst = 1'b1;
    a4 = '0; b4 = '0; c4 = '0;
    a8 = '0; b8 = '0; c8 = '0;
    #1;

    // T1 reset held for two edges
    step(1, 4'h6, 4'h2, 3'b010, 3'b000, 0, 8'hff, 8'h00, 3'b010, 3'b000, 0, "t1_reset_a");
    step(1, 4'h0, 4'hf, 3'b001, 3'b000, 0, 8'h00, 8'h00, 3'b011, 3'b000, 0, "t1_reset_b");

    // T2 / T3 basic less-than, greater-than; T5 width-8 chaining alongside
    step(0, 4'h6, 4'hf, 3'b100, 3'b001, 0, 8'h36, 8'h35, 3'b001, 3'b100, 0, "t2_lt_t5_low_slice");
    step(0, 4'h6, 4'h2, 3'b010, 3'b100, 0, 8'h35, 8'h35, 3'b001, 3'b001, 0, "t3_gt_t5_tie");

    // T4 tie pass-through, back-to-back
    step(0, 4'h6, 4'h6, 3'b001, 3'b001, 0, 8'hff, 8'h00, 3'b001, 3'b100, 0, "t4_tie_lt");
    step(0, 4'h6, 4'h6, 3'b100, 3'b100, 0, 8'h00, 8'hff, 3'b100, 3'b001, 0, "t4_tie_gt");
    step(0, 4'h6, 4'h6, 3'b010, 3'b010, 0, 8'h00, 8'h00, 3'b010, 3'b010, 0, "t4_tie_eq");

    // Boundaries: extremes and all-equal with legal and illegal cascade codes
    step(0, 4'hf, 4'h0, 3'b001, 3'b100, 0, 8'h53, 8'h63, 3'b100, 3'b001, 0, "bnd_max_min");
    step(0, 4'h0, 4'hf, 3'b100, 3'b001, 0, 8'hff, 8'hff, 3'b000, 3'b000, 1, "bnd_min_max");
    step(0, 4'h0, 4'h0, 3'b100, 3'b100, 0, 8'hff, 8'hff, 3'b100, 3'b100, 0, "bnd_zero_tie");
    step(0, 4'hf, 4'hf, 3'b111, 3'b111, 1, 8'h00, 8'h00, 3'b110, 3'b110, 1, "bnd_ones_illegal");

    // T6 cascade-code check
    step(0, 4'h6, 4'h6, 3'b011, 3'b011, 1, 8'h70, 8'h6f, 3'b011, 3'b100, 0, "t6_illegal_tie");
    step(0, 4'h7, 4'h6, 3'b000, 3'b100, 0, 8'h12, 8'h12, 3'b001, 3'b001, 0, "t6_illegal_no_tie");

    // Reset mid-stream discards the pending result
    step(1, 4'h9, 4'h1, 3'b010, 3'b000, 0, 8'h91, 8'h19, 3'b111, 3'b000, 0, "mid_reset");
    step(0, 4'h1, 4'h9, 3'b010, 3'b001, 0, 8'h19, 8'h91, 3'b010, 3'b001, 0, "post_reset");

    // Randomised vectors against the reference, biased toward ties and occasional reset
    for (int i = 0; i < 1000; i++) begin
      r   = ($urandom_range(0, 19) == 0);
      ra4 = 4'($urandom);
      rb4 = ($urandom_range(0, 2) == 0) ? ra4 : 4'($urandom);
      rc4 = 3'($urandom);
      ra8 = 8'($urandom);
      case ($urandom_range(0, 3))
        0:       rb8 = ra8;
        1:       rb8 = {ra8[7:4], 4'($urandom)};
        default: rb8 = 8'($urandom);
      endcase
      rc8 = 3'($urandom);
      step(r,
           ra4, rb4, rc4,
           r ? 3'b000 : refCmp(ra4, rb4, rc4), r ? 1'b0 : refErr(ra4, rb4, rc4),
           ra8, rb8, rc8,
           r ? 3'b000 : refCmp(ra8, rb8, rc8), r ? 1'b0 : refErr(ra8, rb8, rc8),
           "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
